// File: rtl/vedic_mac_pkg.sv
// Shared types and default widths for the vedic multiply-accumulate stage.
package vedic_mac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } mac_state_t;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_LEN_WIDTH = 8;
    localparam int DEF_ACC_WIDTH = 2 * DEF_WIDTH + 8;

endpackage

// File: rtl/vedic_mult.sv
// Combinational unsigned Vedic (Urdhva Tiryagbhyam) multiplier, built recursively
// from 2x2 blocks; WIDTH must be a power of two and at least 2.
module vedic_mult #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] p
);

    generate
        if (WIDTH == 2) begin : g_base
            logic cross_s;
            logic cross_c_s;
            logic hi_s;

            assign cross_s   = (a[1] & b[0]) ^ (a[0] & b[1]);
            assign cross_c_s = (a[1] & b[0]) & (a[0] & b[1]);
            assign hi_s      = a[1] & b[1];
            assign p         = {hi_s & cross_c_s, hi_s ^ cross_c_s, cross_s, a[0] & b[0]};
        end else begin : g_rec
            localparam int H = WIDTH / 2;
            logic [WIDTH-1:0] ll_s;
            logic [WIDTH-1:0] lh_s;
            logic [WIDTH-1:0] hl_s;
            logic [WIDTH-1:0] hh_s;

            vedic_mult #(.WIDTH(H)) u_ll (.a(a[H-1:0]),     .b(b[H-1:0]),     .p(ll_s));
            vedic_mult #(.WIDTH(H)) u_lh (.a(a[H-1:0]),     .b(b[WIDTH-1:H]), .p(lh_s));
            vedic_mult #(.WIDTH(H)) u_hl (.a(a[WIDTH-1:H]), .b(b[H-1:0]),     .p(hl_s));
            vedic_mult #(.WIDTH(H)) u_hh (.a(a[WIDTH-1:H]), .b(b[WIDTH-1:H]), .p(hh_s));

            // Cross terms land at bit H of the full-width product.
            assign p = {hh_s, ll_s}
                     + {{H{1'b0}}, lh_s, {H{1'b0}}}
                     + {{H{1'b0}}, hl_s, {H{1'b0}}};
        end
    endgenerate

endmodule

// File: rtl/vedic_mac_seq.sv
// Sequential multiply-accumulate (dot-product) engine around one vedic_mult.
// Optional feature: define VEDIC_MAC_SAT_EN to saturate the accumulator instead of wrapping.
module vedic_mac_seq
    import vedic_mac_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ACC_WIDTH = 2 * WIDTH + 8,
    parameter int LEN_WIDTH = DEF_LEN_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] len,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] acc_out,
    output logic                 overflow,
    output logic                 busy
);

    localparam logic [LEN_WIDTH-1:0] CNT_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

    mac_state_t           state_r;
    mac_state_t           state_next_s;
    logic [LEN_WIDTH-1:0] len_r;
    logic [LEN_WIDTH-1:0] cnt_r;
    logic [LEN_WIDTH-1:0] cnt_inc_s;
    logic [WIDTH-1:0]     op_a_r;
    logic [WIDTH-1:0]     op_b_r;
    logic                 pv_r;
    logic [ACC_WIDTH-1:0] acc_r;
    logic                 ovf_r;
    logic                 in_ready_r;
    logic                 out_valid_r;
    logic                 busy_r;
    logic [2*WIDTH-1:0]   prod_s;
    logic [ACC_WIDTH:0]   sum_s;
    logic [ACC_WIDTH-1:0] acc_add_s;
    logic                 accept_s;
    logic                 job_clear_s;

    vedic_mult #(.WIDTH(WIDTH)) u_mult (
        .a (op_a_r),
        .b (op_b_r),
        .p (prod_s)
    );

    assign accept_s  = in_valid & in_ready_r;
    assign cnt_inc_s = cnt_r + CNT_ONE;

    // Next-state decode and job-start strobe.
    always_comb begin
        state_next_s = state_r;
        job_clear_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    job_clear_s  = 1'b1;
                    state_next_s = (len == {LEN_WIDTH{1'b0}}) ? DONE : RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (accept_s && (cnt_inc_s == len_r)) begin
                    state_next_s = DRAIN;
                end else begin
                    state_next_s = RUN;
                end
            end
            DRAIN: state_next_s = DONE;
            DONE: begin
                if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Accumulator adder with the carry kept as an extra top bit.
    always_comb begin
        sum_s = {1'b0, acc_r} + {{(ACC_WIDTH - 2*WIDTH + 1){1'b0}}, prod_s};
`ifdef VEDIC_MAC_SAT_EN
        if (sum_s[ACC_WIDTH]) begin
            acc_add_s = {ACC_WIDTH{1'b1}};
        end else begin
            acc_add_s = sum_s[ACC_WIDTH-1:0];
        end
`else
        acc_add_s = sum_s[ACC_WIDTH-1:0];
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath registers and registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_r       <= {LEN_WIDTH{1'b0}};
            cnt_r       <= {LEN_WIDTH{1'b0}};
            op_a_r      <= {WIDTH{1'b0}};
            op_b_r      <= {WIDTH{1'b0}};
            pv_r        <= 1'b0;
            acc_r       <= {ACC_WIDTH{1'b0}};
            ovf_r       <= 1'b0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            if (job_clear_s) begin
                len_r <= len;
                cnt_r <= {LEN_WIDTH{1'b0}};
                pv_r  <= 1'b0;
                acc_r <= {ACC_WIDTH{1'b0}};
                ovf_r <= 1'b0;
            end else begin
                if (accept_s) begin
                    op_a_r <= a;
                    op_b_r <= b;
                    cnt_r  <= cnt_inc_s;
                end
                pv_r <= accept_s;
                // The product of the beat registered last cycle is summed now.
                if (pv_r) begin
                    acc_r <= acc_add_s;
                    ovf_r <= ovf_r | sum_s[ACC_WIDTH];
                end
            end
            in_ready_r  <= (state_next_s == RUN);
            out_valid_r <= (state_next_s == DONE);
            busy_r      <= (state_next_s != IDLE);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign acc_out   = acc_r;
    assign overflow  = ovf_r;

endmodule

// File: tb/tb_vedic_mac_seq.sv
// Scoreboard bench for vedic_mac_seq (ACC_WIDTH=16) with an arithmetic dot-product model.
module tb_vedic_mac_seq;

    localparam int WIDTH     = 8;
    localparam int ACC_WIDTH = 16;
    localparam int LEN_WIDTH = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [LEN_WIDTH-1:0] len;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] acc_out;
    logic                 overflow;
    logic                 busy;

    typedef struct {
        logic [ACC_WIDTH-1:0] acc;
        logic                 ovf;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   beat_a[$];
    int   beat_b[$];
    int   gap_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic prev_hold = 1'b0;
    logic [ACC_WIDTH-1:0] prev_acc = '0;

    vedic_mac_seq #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH), .LEN_WIDTH(LEN_WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_out   (acc_out),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every result transfer and checks holding behaviour.
    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (out_valid) check("in_ready_with_out_valid", in_ready, 0);
            if (out_valid && prev_hold) check("acc_held_stable", acc_out, prev_acc);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_result: got acc 0x%0h, expected no result", acc_out);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("acc_out", acc_out, mon_e.acc);
                    check("overflow", overflow, mon_e.ovf);
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_acc  = acc_out;
        end
    end

    // Reference: true sum of products, then wrap or clamp to ACC_WIDTH bits.
    function automatic exp_t model(input int n);
        longint sum;
        longint limit;
        exp_t   e;
        sum   = 0;
        limit = longint'(1) << ACC_WIDTH;
        for (int i = 0; i < n; i++) sum += longint'(beat_a[i]) * longint'(beat_b[i]);
        e.ovf = (sum >= limit);
`ifdef VEDIC_MAC_SAT_EN
        e.acc = (sum >= limit) ? {ACC_WIDTH{1'b1}} : ACC_WIDTH'(sum);
`else
        e.acc = ACC_WIDTH'(sum % limit);
`endif
        return e;
    endfunction

    task automatic add_beat(input int av, input int bv, input int gap);
        beat_a.push_back(av);
        beat_b.push_back(bv);
        gap_q.push_back(gap);
    endtask

    task automatic run_job(input int n, input int rdy_delay, input bit pulse_start, input bit start_on_exit);
        int cyc;
        @(posedge clk); #1;
        start = 1'b1;
        len   = LEN_WIDTH'(n);
        exp_q.push_back(model(n));
        @(posedge clk); #1;
        start = 1'b0;
        if (n == 0) begin
            @(negedge clk);
            check("zero_len_out_valid", out_valid, 1);
            check("zero_len_in_ready", in_ready, 0);
        end
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b0;
            repeat (gap_q[i]) begin
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            a = WIDTH'(beat_a[i]);
            b = WIDTH'(beat_b[i]);
            if (pulse_start && i == 0) begin
                start = 1'b1;
                len   = 8'd5;
            end
            cyc = 0;
            @(negedge clk);
            while (!in_ready && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            check("beat_accepted", in_ready, 1);
            @(posedge clk); #1;
            start = 1'b0;
        end
        in_valid = 1'b0;
        if (n != 0) begin
            @(negedge clk);
            check("drain_out_valid", out_valid, 0);
            check("drain_in_ready", in_ready, 0);
            check("drain_busy", busy, 1);
            @(negedge clk);
            check("result_latency", out_valid, 1);
        end
        @(posedge clk); #1;
        repeat (rdy_delay) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        if (start_on_exit) begin
            start = 1'b1;
            len   = 8'd0;
        end
        cyc = 0;
        @(negedge clk);
        while (!out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("result_transfer", out_valid, 1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        start     = 1'b0;
        @(negedge clk);
        check("busy_after_transfer", busy, 0);
        check("out_valid_after_transfer", out_valid, 0);
        beat_a.delete();
        beat_b.delete();
        gap_q.delete();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
        a = '0; b = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", in_ready, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_overflow", overflow, 0);
        check("reset_acc", acc_out, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic dot product: 15 + 65025 + 256 = 0xFF10.
        add_beat(3, 5, 0); add_beat(255, 255, 0); add_beat(16, 16, 0);
        run_job(3, 0, 1'b0, 1'b0);

        // Zero-length job, with a start attempted on the DONE->IDLE cycle.
        run_job(0, 1, 1'b0, 1'b1);

        // Overflow: 2*65025 exceeds 16 bits.
        add_beat(255, 255, 0); add_beat(255, 255, 0);
        run_job(2, 0, 1'b0, 1'b0);

        // Stalls on both sides: 100 + 400 = 500.
        add_beat(10, 10, 0); add_beat(20, 20, 3);
        run_job(2, 4, 1'b0, 1'b0);

        // Reset mid-job after one beat.
        @(posedge clk); #1;
        start = 1'b1; len = 8'd4;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1; a = 8'd1; b = 8'd2;
        @(posedge clk); #1;
        in_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_in_ready", in_ready, 0);
        check("abort_busy", busy, 0);
        check("abort_acc", acc_out, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_no_out_valid", out_valid, 0);
        end

        // Fresh job with start pulsed during RUN: 7*9 = 63.
        add_beat(7, 9, 0);
        run_job(1, 0, 1'b1, 1'b0);

        // Randomized jobs, biased toward large operands to exercise overflow.
        for (int j = 0; j < 25; j++) begin
            int n;
            n = int'($urandom_range(1, 6));
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0)
                    add_beat(255, int'($urandom_range(200, 255)), int'($urandom_range(0, 2)));
                else
                    add_beat(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 2)));
            end
            run_job(n, int'($urandom_range(0, 3)), 1'(j % 5 == 0), 1'(j % 7 == 0));
        end

        repeat (3) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected run completion");
        $fatal(1, "watchdog expired");
    end

endmodule
